// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents the fetched word to the controller as IR_out. Handles downstream
// stall and taken-branch redirect, discarding any fetch that is in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'hF000_0000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] IR_out,
  output logic        IR_valid,
  output logic [31:0] PC_out,
  output logic [31:0] PC_plus8
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;           // next PC / pending redirect target
  logic [31:0] addr_q, addr_d;       // address currently presented to memory
  logic [31:0] ir_q, ir_d;           // last fetched word (masked when invalid)
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] pc_out_q, pc_out_d;

  logic [31:0] target_aligned;
  logic [31:0] addr_plus4;
  logic        consumed;

  assign target_aligned = branch_target & ~32'h0000_0003;
  assign addr_plus4     = addr_q + 32'd4;
  assign consumed       = ir_valid_q && !stall;

  // Request is only withheld in FETCH when a valid IR is stuck behind a stall.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_IDLE:    imem_req = 1'b0;
      S_FETCH:   imem_req = !(ir_valid_q && stall);
      S_DISCARD: imem_req = 1'b1;
      default:   imem_req = 1'b0;
    endcase
  end

  // Next-state logic; a taken branch takes priority over stall and ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_out_d   = pc_out_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken) begin
          ir_valid_d = 1'b0;
          pc_d       = target_aligned;
          addr_d     = target_aligned;
        end
      end

      S_FETCH: begin
        if (branch_taken) begin
          ir_valid_d = 1'b0;
          pc_d       = target_aligned;
          if (imem_req && !imem_ack) begin
            // Memory is still working on the old address; keep it stable.
            state_d = S_DISCARD;
          end else begin
            addr_d = target_aligned;
          end
        end else if (imem_req && imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          pc_out_d   = addr_q;
          pc_d       = addr_plus4;
          addr_d     = addr_plus4;
        end else if (imem_req) begin
          if (consumed) begin
            ir_valid_d = 1'b0;
          end
        end
      end

      S_DISCARD: begin
        ir_valid_d = 1'b0;
        if (branch_taken) begin
          pc_d = target_aligned;
        end
        if (imem_ack) begin
          // Returned word belongs to the abandoned path and is dropped.
          state_d = S_FETCH;
          addr_d  = branch_taken ? target_aligned : pc_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      ir_q       <= NOP_IR;
      ir_valid_q <= 1'b0;
      pc_out_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign imem_addr = addr_q;
  assign IR_valid  = ir_valid_q;
  assign IR_out    = ir_valid_q ? ir_q : NOP_IR;
  assign PC_out    = pc_out_q;
  assign PC_plus8  = pc_out_q + 32'd8;

endmodule
